// File: rtl/aib_mac_ch_traffic_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : aib_mac_ch_traffic_if
//  Purpose  : Channel-side bundle between the MAC traffic block and the AIB
//             channel datapath (TX word out, RX word in, path-ready strobes).
//  Ports    : ms_tx_transfer_en - TX path ready
//             ms_rx_transfer_en - RX path ready
//             data_out_f        - word received from the PHY
//             data_in_f         - word transmitted to the PHY
//  Modports : master - MAC side (traffic generator/checker)
//             slave  - PHY/channel side
//  Revision : 1.0 - initial release
// ============================================================================
interface aib_mac_ch_traffic_if #(
    parameter int DWIDTH = 40
);
    logic                  ms_tx_transfer_en;
    logic                  ms_rx_transfer_en;
    logic [DWIDTH*8-1:0]   data_out_f;
    logic [DWIDTH*8-1:0]   data_in_f;

    modport master (
        input  ms_tx_transfer_en,
        input  ms_rx_transfer_en,
        input  data_out_f,
        output data_in_f
    );

    modport slave (
        output ms_tx_transfer_en,
        output ms_rx_transfer_en,
        output data_out_f,
        input  data_in_f
    );
endinterface
`default_nettype wire

// File: rtl/aib_mac_ch_traffic.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : aib_mac_ch_traffic
//  Purpose  : Per-channel MAC-side traffic generator and loopback checker for
//             AIB bring-up. Sends patterned words (seed + k*NSEG + j per
//             segment), hunts for word 0 on the return path, then checks every
//             enabled word, counting errors and producing a pass/fail verdict.
//  Ports    : m_wr_clk, ns_adapter_rstn (async active-low)
//             i_mode, i_start, i_num_words, i_seed   - run configuration
//             ch (master)                            - TX/RX words and enables
//             o_busy, o_done, o_pass, o_err_cnt,
//             o_hunt_timeout, o_rx_word_cnt          - status
//  Option   : AIB_TRAFFIC_ERR_INJ_EN adds i_err_inj (flip bit 0 of the next
//             driven word) and o_inj_cnt (injected word count).
//  Revision : 1.0 - initial release
// ============================================================================
module aib_mac_ch_traffic #(
    parameter int DWIDTH       = 40,
    parameter int CNTW         = 16,
    parameter int HUNT_TIMEOUT = 1024
) (
    input  logic                m_wr_clk,
    input  logic                ns_adapter_rstn,
    input  logic [1:0]          i_mode,
    input  logic                i_start,
    input  logic [CNTW-1:0]     i_num_words,
    input  logic [DWIDTH-1:0]   i_seed,
`ifdef AIB_TRAFFIC_ERR_INJ_EN
    input  logic                i_err_inj,
    output logic [15:0]         o_inj_cnt,
`endif
    aib_mac_ch_traffic_if.master ch,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_pass,
    output logic [15:0]         o_err_cnt,
    output logic                o_hunt_timeout,
    output logic [CNTW-1:0]     o_rx_word_cnt
);
    localparam int BW  = DWIDTH * 8;
    localparam int HCW = $clog2(HUNT_TIMEOUT + 1);

    typedef enum logic [1:0] {G_IDLE = 2'd0, G_RUN = 2'd1, G_DONE = 2'd2} gstate_t;
    typedef enum logic [1:0] {C_IDLE = 2'd0, C_HUNT = 2'd1, C_CHECK = 2'd2, C_DONE = 2'd3} cstate_t;

    function automatic logic [3:0] f_nseg(input logic [1:0] m);
        case (m)
            2'd3:    f_nseg = 4'd8;
            2'd2:    f_nseg = 4'd4;
            default: f_nseg = 4'd2;
        endcase
    endfunction

    // Word whose segment j is base+j; segments beyond NSEG stay zero.
    function automatic logic [BW-1:0] f_word(input logic [DWIDTH-1:0] base, input logic [1:0] m);
        logic [BW-1:0] w;
        w = '0;
        for (int j = 0; j < 8; j++) begin
            if (j < int'(f_nseg(m))) w[j*DWIDTH +: DWIDTH] = base + DWIDTH'(j);
        end
        return w;
    endfunction

    function automatic logic [BW-1:0] f_mask(input logic [1:0] m);
        logic [BW-1:0] w;
        w = '0;
        for (int j = 0; j < 8; j++) begin
            if (j < int'(f_nseg(m))) w[j*DWIDTH +: DWIDTH] = '1;
        end
        return w;
    endfunction

    gstate_t            r_gstate;
    cstate_t            r_cstate;
    logic [1:0]         r_mode;
    logic [CNTW-1:0]    r_num;
    logic [CNTW-1:0]    r_gk;
    logic [DWIDTH-1:0]  r_gbase;      // seed + k*NSEG for the next TX word
    logic [DWIDTH-1:0]  r_cbase;      // seed + idx*NSEG for the next expected word
    logic [HCW-1:0]     r_hunt;
    logic [BW-1:0]      r_data;
    logic               r_busy, r_done, r_pass, r_hto;
    logic [15:0]        r_err_cnt;
    logic [CNTW-1:0]    r_rx_cnt;

    logic               w_accept, w_drive, w_mismatch, w_both_done, w_inj;
    logic [DWIDTH-1:0]  w_step;
    logic [BW-1:0]      w_gword;
    logic [15:0]        w_err_inc;
    logic [CNTW-1:0]    w_cnt_inc;

    assign w_accept    = i_start && (r_gstate == G_IDLE) && !r_busy;
    assign w_drive     = (r_gstate == G_RUN) && (r_num != '0) && ch.ms_tx_transfer_en;
    assign w_step      = DWIDTH'(f_nseg(r_mode));
    assign w_mismatch  = (ch.data_out_f & f_mask(r_mode)) != f_word(r_cbase, r_mode);
    assign w_both_done = (r_gstate == G_DONE) && (r_cstate == C_DONE);
    assign w_err_inc   = (r_err_cnt == 16'hFFFF) ? r_err_cnt : r_err_cnt + 16'd1;
    assign w_cnt_inc   = r_rx_cnt + CNTW'(1);

`ifdef AIB_TRAFFIC_ERR_INJ_EN
    logic               r_inj_pend;
    logic [15:0]        r_inj_cnt;
    // A pulse coinciding with a drive edge hits that word; otherwise it waits.
    assign w_inj     = r_inj_pend || i_err_inj;
    assign o_inj_cnt = r_inj_cnt;
`else
    assign w_inj     = 1'b0;
`endif
    assign w_gword = f_word(r_gbase, r_mode) ^ {{(BW-1){1'b0}}, w_inj};

    always_ff @(posedge m_wr_clk or negedge ns_adapter_rstn) begin
        if (!ns_adapter_rstn) begin
            r_gstate  <= G_IDLE;
            r_cstate  <= C_IDLE;
            r_mode    <= '0;
            r_num     <= '0;
            r_gk      <= '0;
            r_gbase   <= '0;
            r_cbase   <= '0;
            r_hunt    <= '0;
            r_data    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_hto     <= 1'b0;
            r_err_cnt <= '0;
            r_rx_cnt  <= '0;
`ifdef AIB_TRAFFIC_ERR_INJ_EN
            r_inj_pend <= 1'b0;
            r_inj_cnt  <= '0;
`endif
        end else if (w_accept) begin
            r_gstate  <= G_RUN;
            r_cstate  <= C_HUNT;
            r_mode    <= i_mode;
            r_num     <= i_num_words;
            r_gk      <= '0;
            r_gbase   <= i_seed;
            r_cbase   <= i_seed;
            r_hunt    <= '0;
            r_data    <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_hto     <= 1'b0;
            r_err_cnt <= '0;
            r_rx_cnt  <= '0;
`ifdef AIB_TRAFFIC_ERR_INJ_EN
            r_inj_pend <= 1'b0;
            r_inj_cnt  <= '0;
`endif
        end else begin
            // ---------------- generator ----------------
            case (r_gstate)
                G_RUN: begin
                    if (r_num == '0) begin
                        r_gstate <= G_IDLE;            // zero-length run: nothing to send
                    end else if (w_drive) begin
                        r_data  <= w_gword;
                        r_gbase <= r_gbase + w_step;
                        r_gk    <= r_gk + CNTW'(1);
                        if (r_gk == r_num - CNTW'(1)) r_gstate <= G_DONE;
                    end
                end
                G_DONE: begin
                    r_data <= '0;
                    if (w_both_done) r_gstate <= G_IDLE;
                end
                default: ;
            endcase

            // ---------------- checker ----------------
            case (r_cstate)
                C_HUNT: begin
                    if (r_num == '0) begin
                        r_cstate <= C_IDLE;            // zero-length run finishes at once
                        r_done   <= 1'b1;
                        r_pass   <= 1'b1;
                        r_busy   <= 1'b0;
                    end else if (ch.ms_rx_transfer_en && !w_mismatch) begin
                        r_rx_cnt <= CNTW'(1);
                        r_cbase  <= r_cbase + w_step;
                        if (r_num == CNTW'(1)) begin
                            r_cstate <= C_DONE;
                            r_done   <= 1'b1;
                            r_pass   <= 1'b1;
                        end else begin
                            r_cstate <= C_CHECK;
                        end
                    end else if (r_hunt == HCW'(HUNT_TIMEOUT - 1)) begin
                        r_cstate <= C_DONE;
                        r_hto    <= 1'b1;
                        r_done   <= 1'b1;
                        r_pass   <= 1'b0;
                    end else begin
                        r_hunt <= r_hunt + HCW'(1);
                    end
                end
                C_CHECK: begin
                    if (ch.ms_rx_transfer_en) begin
                        r_cbase  <= r_cbase + w_step;
                        r_rx_cnt <= w_cnt_inc;
                        if (w_mismatch) r_err_cnt <= w_err_inc;
                        if (w_cnt_inc == r_num) begin
                            r_cstate <= C_DONE;
                            r_done   <= 1'b1;
                            r_pass   <= !w_mismatch && (r_err_cnt == '0);
                        end
                    end
                end
                C_DONE: begin
                    if (w_both_done) begin
                        r_cstate <= C_IDLE;
                        r_busy   <= 1'b0;
                    end
                end
                default: ;
            endcase

`ifdef AIB_TRAFFIC_ERR_INJ_EN
            if (w_drive) begin
                r_inj_pend <= 1'b0;
                if (w_inj && r_inj_cnt != 16'hFFFF) r_inj_cnt <= r_inj_cnt + 16'd1;
            end else if (r_gstate == G_RUN && i_err_inj) begin
                r_inj_pend <= 1'b1;
            end
`endif
        end
    end

    assign ch.data_in_f    = r_data;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_pass          = r_pass;
    assign o_err_cnt       = r_err_cnt;
    assign o_hunt_timeout  = r_hto;
    assign o_rx_word_cnt   = r_rx_cnt;
endmodule
`default_nettype wire

// File: tb/tb_aib_mac_ch_traffic.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_aib_mac_ch_traffic
//  Purpose  : Directed bench for aib_mac_ch_traffic with a configurable
//             loopback (latency 0..3, optional word corruption, or cut) and a
//             scoreboard of expected TX words. Honours AIB_TRAFFIC_ERR_INJ_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aib_mac_ch_traffic;
    localparam int DW = 40;
    localparam int BW = DW * 8;
    localparam int HT = 1024;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     mode;
    logic           start;
    logic [15:0]    num;
    logic [DW-1:0]  seed;
    logic           busy, done, pass, hto;
    logic [15:0]    err, rxcnt;
`ifdef AIB_TRAFFIC_ERR_INJ_EN
    logic           err_inj;
    logic [15:0]    inj_cnt;
`endif

    always #5 clk = ~clk;

    aib_mac_ch_traffic_if #(.DWIDTH(DW)) ch();

    aib_mac_ch_traffic #(.DWIDTH(DW), .CNTW(16), .HUNT_TIMEOUT(HT)) dut (
        .m_wr_clk        (clk),
        .ns_adapter_rstn (rst_n),
        .i_mode          (mode),
        .i_start         (start),
        .i_num_words     (num),
        .i_seed          (seed),
`ifdef AIB_TRAFFIC_ERR_INJ_EN
        .i_err_inj       (err_inj),
        .o_inj_cnt       (inj_cnt),
`endif
        .ch              (ch),
        .o_busy          (busy),
        .o_done          (done),
        .o_pass          (pass),
        .o_err_cnt       (err),
        .o_hunt_timeout  (hto),
        .o_rx_word_cnt   (rxcnt)
    );

    // ---------------- loopback model ----------------
    int             lat;
    bit             no_loop, corrupt_en;
    logic           tx_en, rx_en;
    logic [BW-1:0]  corrupt_word, flip, loop_word;
    logic [BW-1:0]  dpipe [0:2];
    logic           epipe [0:3];

    always @(posedge clk) begin
        dpipe[0] <= ch.data_in_f;
        dpipe[1] <= dpipe[0];
        dpipe[2] <= dpipe[1];
        epipe[0] <= tx_en;
        epipe[1] <= epipe[0];
        epipe[2] <= epipe[1];
        epipe[3] <= epipe[2];
    end

    always_comb begin
        loop_word = ch.data_in_f;
        rx_en     = epipe[0];
        case (lat)
            1: begin loop_word = dpipe[0]; rx_en = epipe[1]; end
            2: begin loop_word = dpipe[1]; rx_en = epipe[2]; end
            3: begin loop_word = dpipe[2]; rx_en = epipe[3]; end
            default: ;
        endcase
    end

    assign ch.ms_tx_transfer_en = tx_en;
    assign ch.ms_rx_transfer_en = rx_en;
    assign ch.data_out_f = no_loop ? '0 :
                           (corrupt_en && loop_word == corrupt_word) ? (loop_word ^ flip) : loop_word;

    // ---------------- scoreboard ----------------
    logic [BW-1:0]  q_exp [$];
    logic [BW-1:0]  last_word;
    bit             sending, inj_due;
    int             n_assert = 0;
    int             n_fail   = 0;

    function automatic logic [BW-1:0] model_word(input logic [DW-1:0] s, input logic [1:0] m, input int k);
        int ns;
        logic [BW-1:0] w;
        ns = (m == 2'd3) ? 8 : (m == 2'd2) ? 4 : 2;
        w  = '0;
        for (int j = 0; j < ns; j++) w[j*DW +: DW] = s + DW'(k * ns + j);
        return w;
    endfunction

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample TX enable at the edge, then compare the driven word.
    task automatic tick();
        logic          en;
        logic [BW-1:0] e;
        @(posedge clk);
        en = tx_en;
        #1;
        if (sending) begin
            if (en) begin
                e = q_exp.pop_front();
                if (inj_due) begin
                    e[0]    = ~e[0];
                    inj_due = 1'b0;
                end
                check("tx_word", ch.data_in_f, e);
                last_word = e;
                if (q_exp.size() == 0) sending = 1'b0;
            end else begin
                check("tx_hold", ch.data_in_f, last_word);
            end
        end
    endtask

    task automatic start_run(input logic [1:0] m, input logic [DW-1:0] s, input logic [15:0] n);
        mode = m;
        seed = s;
        num  = n;
        q_exp.delete();
        for (int k = 0; k < int'(n); k++) q_exp.push_back(model_word(s, m, k));
        inj_due = 1'b0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        sending = (n != 16'd0);
        check("busy_after_start", BW'(busy), BW'(1'b1));
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (done !== 1'b1 && c < budget) begin
            tick();
            c++;
        end
        check("done_within_budget", BW'(done), BW'(1'b1));
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while (busy !== 1'b0 && c < budget) begin
            tick();
            c++;
        end
        check("idle_within_budget", BW'(busy), BW'(1'b0));
    endtask

    task automatic check_result(input bit e_pass, input int e_err, input int e_cnt, input bit e_hto);
        check("done",     BW'(done),  BW'(1'b1));
        check("pass",     BW'(pass),  BW'(e_pass));
        check("err_cnt",  BW'(err),   BW'(e_err));
        check("rx_cnt",   BW'(rxcnt), BW'(e_cnt));
        check("hunt_to",  BW'(hto),   BW'(e_hto));
        check("sb_empty", BW'(q_exp.size()), BW'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = '0; num = '0; seed = '0;
        tx_en = 1'b1; lat = 0; no_loop = 1'b0; corrupt_en = 1'b0;
        corrupt_word = '0; flip = '0; flip[3*DW] = 1'b1;
        sending = 1'b0; inj_due = 1'b0; last_word = '0;
`ifdef AIB_TRAFFIC_ERR_INJ_EN
        err_inj = 1'b0;
`endif
        repeat (5) @(posedge clk);
        #1;
        check("rst_busy",  BW'(busy),  '0);
        check("rst_done",  BW'(done),  '0);
        check("rst_pass",  BW'(pass),  '0);
        check("rst_err",   BW'(err),   '0);
        check("rst_hto",   BW'(hto),   '0);
        check("rst_rxcnt", BW'(rxcnt), '0);
        check("rst_data",  ch.data_in_f, '0);
`ifdef AIB_TRAFFIC_ERR_INJ_EN
        check("rst_inj_cnt", BW'(inj_cnt), '0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick();

        // Mode 1, 0-cycle loopback; a second start mid-run must be ignored.
        lat = 0;
        start_run(2'd1, 40'h10, 16'd8);
        tick();
        check("m1_w0_seg0", BW'(ch.data_in_f[DW-1:0]), BW'(40'h10));
        tick();
        check("m1_w1_seg0", BW'(ch.data_in_f[DW-1:0]), BW'(40'h12));
        mode = 2'd3; seed = 40'h999; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(100);
        check_result(1'b1, 0, 8, 1'b0);
        wait_idle(20);
        check("done_sticky", BW'(done), BW'(1'b1));

        // Mode 3, seed near wrap, 3-cycle loopback.
        lat = 3;
        start_run(2'd3, 40'hFFFFFFFFFE, 16'd6);
        tick();
        check("m3_w0_seg1", BW'(ch.data_in_f[2*DW-1:DW]),   BW'(40'hFFFFFFFFFF));
        check("m3_w0_seg2", BW'(ch.data_in_f[3*DW-1:2*DW]), BW'(40'h0));
        check("m3_w0_seg7", BW'(ch.data_in_f[8*DW-1:7*DW]), BW'(40'h5));
        wait_done(100);
        check_result(1'b1, 0, 6, 1'b0);
        wait_idle(20);

        // Mode 2, word 5 segment 3 corrupted in the loopback.
        lat = 1;
        corrupt_word = model_word(40'h300, 2'd2, 5);
        corrupt_en = 1'b1;
        start_run(2'd2, 40'h300, 16'd8);
        wait_done(100);
        check_result(1'b0, 1, 8, 1'b0);
        wait_idle(20);
        corrupt_en = 1'b0;

        // TX stall for 5 cycles mid-run with matching RX gating.
        lat = 2;
        start_run(2'd1, 40'h40, 16'd12);
        repeat (4) tick();
        tx_en = 1'b0;
        repeat (5) tick();
        tx_en = 1'b1;
        wait_done(100);
        check_result(1'b1, 0, 12, 1'b0);
        wait_idle(20);

        // Zero-length run: one busy cycle then an immediate pass.
        lat = 0;
        start_run(2'd1, 40'h55, 16'd0);
        tick();
        check_result(1'b1, 0, 0, 1'b0);
        check("zero_busy", BW'(busy), BW'(1'b0));
        check("zero_data", ch.data_in_f, '0);

        // Cut loopback: hunt timeout exactly HT cycles after the start edge.
        no_loop = 1'b1;
        start_run(2'd1, 40'h20, 16'd4);
        repeat (HT - 1) tick();
        check("hto_not_yet", BW'(done), BW'(1'b0));
        tick();
        check_result(1'b0, 0, 0, 1'b1);
        wait_idle(20);
        no_loop = 1'b0;

        // Error injection on two separate words (words 3 and 8).
        lat = 1;
        start_run(2'd1, 40'h100, 16'd16);
        repeat (3) tick();
`ifdef AIB_TRAFFIC_ERR_INJ_EN
        err_inj = 1'b1; inj_due = 1'b1;
`endif
        tick();
`ifdef AIB_TRAFFIC_ERR_INJ_EN
        err_inj = 1'b0;
`endif
        repeat (4) tick();
`ifdef AIB_TRAFFIC_ERR_INJ_EN
        err_inj = 1'b1; inj_due = 1'b1;
`endif
        tick();
`ifdef AIB_TRAFFIC_ERR_INJ_EN
        err_inj = 1'b0;
`endif
        wait_done(100);
`ifdef AIB_TRAFFIC_ERR_INJ_EN
        check_result(1'b0, 2, 16, 1'b0);
        check("inj_cnt", BW'(inj_cnt), BW'(16'd2));
`else
        check_result(1'b1, 0, 16, 1'b0);
`endif
        wait_idle(20);

        // Asynchronous reset mid-run, with start held during reset.
        start_run(2'd1, 40'h70, 16'd20);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_data",  ch.data_in_f, '0);
        check("arst_busy",  BW'(busy),  '0);
        check("arst_rxcnt", BW'(rxcnt), '0);
        q_exp.delete();
        sending = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rst_beats_start", BW'(busy), '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", BW'(busy), '0);
        start_run(2'd1, 40'h5, 16'd4);
        wait_done(100);
        check_result(1'b1, 0, 4, 1'b0);
        wait_idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
